// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks: FSM state encoding, frame constants
// and the clocks-per-bit helper used to size the bit-timing counter.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    // Frame format is fixed 8N1, LSB first.
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Receiver FSM state encoding.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    // Clock cycles per bit, rounded to nearest.
    function automatic int clks_per_bit(input real clk_freq, input int baud_rate);
        return $rtoi((clk_freq / baud_rate) + 0.5);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Valid/ready byte channel from the UART receiver to its consumer.
//   rx_data  : received byte, stable while rx_valid is high
//   rx_valid : byte available
//   rx_ready : consumer accepts the byte
// master = receiver side (drives data/valid), slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for an asynchronous single-bit input. Both flops reset
// to 1 so an idle-high serial line does not look like a start bit after reset.
//   clk   : destination clock
//   arstn : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronised output
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic arstn,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, delivering bytes over a valid/ready channel.
//   CLK_FREQ  : system clock frequency in Hz (real)
//   BAUD_RATE : line rate in bit/s
//   clk       : system clock, rising edge
//   arstn     : asynchronous active-low reset
//   rxd       : asynchronous serial input, idles high
//   rx_if     : master side of the byte channel (rx_data/rx_valid/rx_ready)
//   rx_busy   : frame in progress (FSM not in IDLE)
//   rx_error  : sticky framing/overrun flag, cleared only by reset
// Build option: define UART_RX_MAJORITY_EN to take every sample as the 2-of-3
// majority around the nominal sample cycle (decision one cycle later).
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter real    CLK_FREQ  = 100_000_000.0,
    parameter integer BAUD_RATE = 4_000_000
) (
    input  logic      clk,
    input  logic      arstn,
    input  logic      rxd,
    uart_rx_if.master rx_if,
    output logic      rx_busy,
    output logic      rx_error
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int BW           = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
    // Majority decision lands one cycle after the nominal start-bit centre;
    // clearing the counter there keeps every later decision one cycle late too.
    localparam logic [CW-1:0] CNT_START = CW'(HALF + 1);
`else
    localparam logic [CW-1:0] CNT_START = CW'(HALF);
`endif

    generate
        if (CLKS_PER_BIT < 4) begin : g_rate_check
            $error("uart_rx: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    logic rxs;

    uart_rx_sync u_sync (
        .clk   (clk),
        .arstn (arstn),
        .d     (rxd),
        .q     (rxs)
    );

    // Line value used for every bit decision.
    logic sample;
`ifdef UART_RX_MAJORITY_EN
    logic hist1_q;
    logic hist2_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            hist1_q <= 1'b1;
            hist2_q <= 1'b1;
        end else begin
            hist1_q <= rxs;
            hist2_q <= hist1_q;
        end
    end

    assign sample = (hist2_q & hist1_q) | (hist2_q & rxs) | (hist1_q & rxs);
`else
    assign sample = rxs;
`endif

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 error_q, error_d;
    logic                 deliver;
    logic                 frame_err;

    // State register
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_START) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A high line at the start-bit centre was only a glitch.
                    state_d = sample ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sample, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    // Leaving at the stop-bit centre leaves half a bit of
                    // margin to catch a back-to-back start bit.
                    state_d = sample ? ST_IDLE : ST_WAIT_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                // Hold off until the line is released so a break does not
                // retrigger frames.
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        rx_busy   = (state_q != ST_IDLE);
        deliver   = (state_q == ST_STOP) && (cnt_q == CNT_LAST) && sample;
        frame_err = (state_q == ST_STOP) && (cnt_q == CNT_LAST) && !sample;
    end

    // Output holding register and sticky error
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        error_d = error_q;
        if (deliver) begin
            if (!valid_q || rx_if.rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                // Overrun: keep the unread byte, drop the new one.
                error_d = 1'b1;
            end
        end else if (rx_if.rx_ready) begin
            valid_d = 1'b0;
        end
        if (frame_err) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign rx_if.rx_data  = data_q;
    assign rx_if.rx_valid = valid_q;
    assign rx_error       = error_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at default parameters (25 clocks per bit).
// Delivered bytes are checked against a scoreboard queue filled as frames are
// driven; protocol corner cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB  = 25;   // 100 MHz / 4 Mbaud
    localparam int HALF = 12;
`ifdef UART_RX_MAJORITY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    // Start falling edge -> 2 sync cycles -> START 1 cycle later -> start
    // sample HALF cycles into START -> 8 data + 1 stop bit at CPB spacing,
    // valid registered on the stop-sample edge.
    localparam int LAT_BUSY  = 3;
    localparam int LAT_VALID = 3 + HALF + 1 + 9 * CPB + EXTRA;

    logic clk   = 1'b0;
    logic arstn = 1'b0;
    logic rxd   = 1'b1;
    logic rx_busy;
    logic rx_error;

    uart_rx_if rx_if ();

    uart_rx dut (
        .clk      (clk),
        .arstn    (arstn),
        .rxd      (rxd),
        .rx_if    (rx_if),
        .rx_busy  (rx_busy),
        .rx_error (rx_error)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         rise_cyc = 0;
    int         busy_rise_cyc = 0;
    int         rise_cnt = 0;
    int         hi_cnt = 0;
    bit         busy_seen = 1'b0;
    logic       valid_prev = 1'b0;
    logic       busy_prev = 1'b0;
    logic [7:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: sample just after the falling edge; a valid&&ready seen here
    // completes on the next rising edge.
    always @(negedge clk) begin
        #1;
        if (arstn) begin
            if (rx_if.rx_valid && !valid_prev) begin
                rise_cnt++;
                rise_cyc = cyc;
            end
            if (rx_if.rx_valid) hi_cnt++;
            if (rx_busy && !busy_prev) busy_rise_cyc = cyc;
            if (rx_busy) busy_seen = 1'b1;
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL xfer_unexpected: got byte 0x%0h, want none", rx_if.rx_data);
                end else begin
                    logic [7:0] exp_b;
                    exp_b = sb.pop_front();
                    check("xfer_data", 32'(rx_if.rx_data), 32'(exp_b));
                    $display("xfer byte 0x%02h (want 0x%02h) at cycle %0d", rx_if.rx_data, exp_b, cyc);
                end
            end
        end
        valid_prev = rx_if.rx_valid;
        busy_prev  = rx_busy;
    end

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = bits[i];
            if (i == 0) start_cyc = cyc;
            repeat (CPB - 1) @(negedge clk);
        end
        $display("sent frame 0x%02h stop=%0b", data, stop_bit);
    endtask

    task automatic do_reset();
        @(negedge clk);
        arstn = 1'b0;
        sb.delete();
        @(negedge clk);
        arstn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        int         gap;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];
    int   base_rise;
    int   base_hi;

    initial begin
        vecs[0] = '{8'h00, 0,  8'h00};
        vecs[1] = '{8'hFF, 0,  8'hFF};
        vecs[2] = '{8'h81, 0,  8'h81};
        vecs[3] = '{8'h5A, 7,  8'h5A};
        vecs[4] = '{8'hC3, 30, 8'hC3};
        vecs[5] = '{8'h01, 0,  8'h01};
        vecs[6] = '{8'h80, 0,  8'h80};

        rx_if.rx_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_data",  32'(rx_if.rx_data), 32'h0);
        check("reset_valid", 32'(rx_if.rx_valid), 32'h0);
        check("reset_busy",  32'(rx_busy), 32'h0);
        check("reset_error", 32'(rx_error), 32'h0);
        @(negedge clk);
        arstn = 1'b1;
        repeat (5) @(negedge clk);

        // 0xA5 with consumer not ready: byte held, latency checked
        base_rise = rise_cnt;
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        repeat (5) @(negedge clk);
        #1;
        check("a5_valid", 32'(rx_if.rx_valid), 32'h1);
        check("a5_data",  32'(rx_if.rx_data), 32'hA5);
        check("a5_error", 32'(rx_error), 32'h0);
        check("a5_rises", 32'(rise_cnt - base_rise), 32'd1);
        check("a5_valid_latency", 32'(rise_cyc - start_cyc), 32'(LAT_VALID));
        check("a5_busy_latency",  32'(busy_rise_cyc - start_cyc), 32'(LAT_BUSY));
        @(negedge clk);
        rx_if.rx_ready = 1'b1;
        @(negedge clk);
        rx_if.rx_ready = 1'b0;
        #1;
        check("a5_valid_after_take", 32'(rx_if.rx_valid), 32'h0);

        // 5-cycle glitch: busy pulses, nothing delivered
        base_rise = rise_cnt;
        busy_seen = 1'b0;
        @(negedge clk);
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        #1;
        check("glitch_busy_seen", 32'(busy_seen), 32'h1);
        check("glitch_busy_end",  32'(rx_busy), 32'h0);
        check("glitch_valid",     32'(rx_if.rx_valid), 32'h0);
        check("glitch_error",     32'(rx_error), 32'h0);
        check("glitch_rises",     32'(rise_cnt - base_rise), 32'd0);

        // Framing error followed by a long break, then a good frame
        base_rise = rise_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (40 * CPB) @(negedge clk);
        #1;
        check("frame_error",      32'(rx_error), 32'h1);
        check("frame_busy_break", 32'(rx_busy), 32'h1);
        check("frame_rises",      32'(rise_cnt - base_rise), 32'd0);
        @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        #1;
        check("frame_busy_released", 32'(rx_busy), 32'h0);
        rx_if.rx_ready = 1'b1;
        sb.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        repeat (10) @(negedge clk);
        #1;
        check("frame_55_delivered", 32'(sb.size()), 32'd0);
        check("frame_55_rises",     32'(rise_cnt - base_rise), 32'd1);
        rx_if.rx_ready = 1'b0;

        // Overrun: 0x11 held, 0x22 dropped
        do_reset();
        check("post_reset_error", 32'(rx_error), 32'h0);
        base_rise = rise_cnt;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (5) @(negedge clk);
        #1;
        check("ovr_data",  32'(rx_if.rx_data), 32'h11);
        check("ovr_error", 32'(rx_error), 32'h1);
        check("ovr_valid", 32'(rx_if.rx_valid), 32'h1);
        check("ovr_rises", 32'(rise_cnt - base_rise), 32'd1);
        @(negedge clk);
        rx_if.rx_ready = 1'b1;
        @(negedge clk);
        rx_if.rx_ready = 1'b0;
        #1;
        check("ovr_valid_after_take", 32'(rx_if.rx_valid), 32'h0);
        check("ovr_sb_empty",         32'(sb.size()), 32'd0);

        // Table-driven stream with ready held high
        do_reset();
        rx_if.rx_ready = 1'b1;
        base_rise = rise_cnt;
        base_hi   = hi_cnt;
        for (int i = 0; i < 7; i++) begin
            sb.push_back(vecs[i].exp);
            send_frame(vecs[i].data, 1'b1);
            repeat (vecs[i].gap) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        #1;
        check("stream_pulses",     32'(rise_cnt - base_rise), 32'd7);
        check("stream_hi_cycles",  32'(hi_cnt - base_hi), 32'd7);
        check("stream_error",      32'(rx_error), 32'h0);
        check("stream_sb_empty",   32'(sb.size()), 32'd0);
        rx_if.rx_ready = 1'b0;

        // Asynchronous reset in the middle of a data phase
        sb.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        send_frame(8'h43, 1'b1);
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (100) @(negedge clk);
                #1;
                check("mid_pre_busy",  32'(rx_busy), 32'h1);
                check("mid_pre_valid", 32'(rx_if.rx_valid), 32'h1);
                check("mid_pre_error", 32'(rx_error), 32'h1);
                #1;
                arstn = 1'b0;
                sb.delete();
                #1;
                check("mid_rst_data",  32'(rx_if.rx_data), 32'h0);
                check("mid_rst_valid", 32'(rx_if.rx_valid), 32'h0);
                check("mid_rst_busy",  32'(rx_busy), 32'h0);
                check("mid_rst_error", 32'(rx_error), 32'h0);
            end
        join
        @(negedge clk);
        arstn = 1'b1;
        base_rise = rise_cnt;
        repeat (2 * CPB) @(negedge clk);
        #1;
        check("mid_no_delivery", 32'(rise_cnt - base_rise), 32'd0);
        check("mid_idle_busy",   32'(rx_busy), 32'h0);
        rx_if.rx_ready = 1'b1;
        sb.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        repeat (10) @(negedge clk);
        #1;
        check("mid_7e_rises", 32'(rise_cnt - base_rise), 32'd1);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
